wb_pwm: RTL and testbench



---
 rtl/wb_pwm_pkg.sv | 36 +++
 rtl/wb_pwm_if.sv | 24 ++
 rtl/wb_pwm_chan.sv | 42 ++++
 rtl/wb_pwm.sv | 145 ++++++++++++++
 tb/tb_wb_pwm.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pwm_pkg.sv
// wb_pwm shared definitions: register map, bit positions, reset values.
// Optional IRQ support is enabled with `define WB_PWM_IRQ_EN.
package wb_pwm_pkg;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_PERIOD = 3'd1,
    REG_DUTY0  = 3'd2,
    REG_DUTY1  = 3'd3,
    REG_DUTY2  = 3'd4,
    REG_DUTY3  = 3'd5,
    REG_STATUS = 3'd6,
    REG_NONE   = 3'd7
  } reg_e;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_POL    = 1;
  localparam int CTRL_IE     = 2;
  localparam int CTRL_PSC    = 8;
  localparam int STATUS_WRAP = 16;

  localparam logic [7:0]  RST_PSC = 8'd0;
  localparam logic [31:0] RST_RDT = 32'd0;

  function automatic logic [31:0] lane_merge(
    input logic [31:0] old,
    input logic [31:0] dat,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = sel[i] ? dat[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/wb_pwm_if.sv
// wb_pwm single-beat wishbone bus bundle.
// Optional IRQ support is enabled with `define WB_PWM_IRQ_EN.
interface wb_pwm_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [7:0]  wb_adr;
  logic [31:0] wb_dat;
  logic [31:0] wb_rdt;
  logic        wb_ack;

  modport master (
    output wb_cyc, wb_stb, wb_we,
    output wb_sel, wb_adr, wb_dat,
    input  wb_rdt, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we,
    input  wb_sel, wb_adr, wb_dat,
    output wb_rdt, wb_ack
  );
endinterface

// File: rtl/wb_pwm_chan.sv
// wb_pwm channel: duty shadow/active pair, compare and output flop.
// Optional IRQ support is enabled with `define WB_PWM_IRQ_EN.
module wb_pwm_chan
  import wb_pwm_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [31:0]   dat,
  input  logic [3:0]    sel,
  input  logic          load,
  input  logic          en,
  input  logic          pol,
  input  logic [CW-1:0] cnt,
  output logic [CW-1:0] shadow,
  output logic          q
);

  logic [CW-1:0] duty;
  logic [31:0]   merged;
  logic          unused_hi;

  assign merged    = lane_merge(32'(shadow), dat, sel);
  assign unused_hi = ^merged[31:CW];

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      duty   <= '0;
      q      <= 1'b0;
    end else begin
      if (wr)
        shadow <= merged[CW-1:0];
      if (load)
        duty <= shadow;
      q <= en ? ((cnt < duty) ^ pol) : pol;
    end
  end

endmodule

// File: rtl/wb_pwm.sv
// wb_pwm: four-channel wishbone PWM with shared prescaler/counter.
// Optional IRQ output and CTRL.IE exist only with `define WB_PWM_IRQ_EN.
module wb_pwm
  import wb_pwm_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic       wb_clk,
  input  logic       wb_rst,
  wb_pwm_if.slave    bus,
  output logic [3:0] pwm_q
`ifdef WB_PWM_IRQ_EN
  ,
  output logic       irq
`endif
);

  reg_e          idx;
  logic          acc;
  logic          wr;
  logic          en;
  logic          pol;
  logic          ie;
  logic [7:0]    psc_max;
  logic [7:0]    psc;
  logic [CW-1:0] per_sh;
  logic [CW-1:0] per;
  logic [CW-1:0] cnt;
  logic          wrap_f;
  logic          tick;
  logic          wrap;
  logic          load;
  logic          en_rise;
  logic [31:0]   ctrl_w;
  logic [31:0]   ctrl_m;
  logic [31:0]   per_m;
  logic [31:0]   rd;
  logic [CW-1:0] duty_sh [4];
  logic          unused_bits;

  assign idx    = reg_e'(bus.wb_adr[4:2]);
  assign acc    = bus.wb_cyc & bus.wb_stb & ~bus.wb_ack;
  assign wr     = acc & bus.wb_we;
  assign ctrl_w = {16'd0, psc_max, 5'd0, ie, pol, en};
  assign ctrl_m = lane_merge(ctrl_w, bus.wb_dat, bus.wb_sel);
  assign per_m  = lane_merge(32'(per_sh), bus.wb_dat, bus.wb_sel);

  assign en_rise = wr & (idx == REG_CTRL) & ctrl_m[CTRL_EN] & ~en;
  assign tick    = en & (psc == psc_max);
  assign wrap    = tick & (cnt == per);
  assign load    = wrap | en_rise;

  assign unused_bits = ^{bus.wb_adr[7:5], bus.wb_adr[1:0],
                         ctrl_m[31:16], ctrl_m[7:2], per_m[31:CW]};

`ifdef WB_PWM_IRQ_EN
  assign irq = wrap_f & ie;

  always_ff @(posedge wb_clk) begin
    if (wb_rst)
      ie <= 1'b0;
    else if (wr && idx == REG_CTRL)
      ie <= ctrl_m[CTRL_IE];
  end
`else
  assign ie = 1'b0;
`endif

  always_comb begin
    rd = '0;
    case (idx)
      REG_CTRL:   rd = ctrl_w;
      REG_PERIOD: rd = 32'(per_sh);
      REG_DUTY0:  rd = 32'(duty_sh[0]);
      REG_DUTY1:  rd = 32'(duty_sh[1]);
      REG_DUTY2:  rd = 32'(duty_sh[2]);
      REG_DUTY3:  rd = 32'(duty_sh[3]);
      REG_STATUS: rd = {15'd0, wrap_f, 16'(cnt)};
      default:    rd = '0;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      bus.wb_ack <= 1'b0;
      bus.wb_rdt <= RST_RDT;
      en         <= 1'b0;
      pol        <= 1'b0;
      psc_max    <= RST_PSC;
      per_sh     <= '0;
      per        <= '0;
      psc        <= RST_PSC;
      cnt        <= '0;
      wrap_f     <= 1'b0;
    end else begin
      bus.wb_ack <= acc;
      if (acc)
        bus.wb_rdt <= rd;
      if (wr && idx == REG_CTRL) begin
        en      <= ctrl_m[CTRL_EN];
        pol     <= ctrl_m[CTRL_POL];
        psc_max <= ctrl_m[CTRL_PSC +: 8];
      end
      if (wr && idx == REG_PERIOD)
        per_sh <= per_m[CW-1:0];
      if (load)
        per <= per_sh;
      if (!en) begin
        psc <= '0;
        cnt <= '0;
      end else if (tick) begin
        psc <= '0;
        cnt <= wrap ? '0 : cnt + CW'(1);
      end else begin
        psc <= psc + 8'd1;
      end
      // a wrap in the same cycle as the W1C keeps the flag set
      if (wrap)
        wrap_f <= 1'b1;
      else if (wr && idx == REG_STATUS && bus.wb_sel[2]
               && bus.wb_dat[STATUS_WRAP])
        wrap_f <= 1'b0;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic dwr;
    assign dwr = wr & (bus.wb_adr[4:2] == 3'(i + 2));

    wb_pwm_chan #(.CW(CW)) u_ch (
      .clk    (wb_clk),
      .rst    (wb_rst),
      .wr     (dwr),
      .dat    (bus.wb_dat),
      .sel    (bus.wb_sel),
      .load   (load),
      .en     (en),
      .pol    (pol),
      .cnt    (cnt),
      .shadow (duty_sh[i]),
      .q      (pwm_q[i])
    );
  end

endmodule

// File: tb/tb_wb_pwm.sv
// wb_pwm bench: register table, scoreboarded reads, PWM waveform model.
// Build with `define WB_PWM_IRQ_EN to also exercise the irq output.
module tb_wb_pwm;

  logic       clk = 1'b0;
  logic       wb_rst = 1'b1;
  logic [3:0] pwm_q;
`ifdef WB_PWM_IRQ_EN
  logic       irq;
`endif

  wb_pwm_if bus ();

  wb_pwm #(.CW(16)) dut (
    .wb_clk (clk),
    .wb_rst (wb_rst),
    .bus    (bus),
    .pwm_q  (pwm_q)
`ifdef WB_PWM_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

  always #5 clk = ~clk;

  localparam int BIG = 1 << 30;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // waveform model: edges are numbered by cyc_n after that edge
  int en_edge  = BIG;
  int psc      = 0;
  int per      = 0;
  int pol_edge = BIG;
  int off_edge = BIG;
  int clr_edge = 0;
  int dold [4];
  int dnew [4];
  int dsw  [4];
  bit mon = 0;

  logic [31:0] sbq [$];

  typedef struct {
    logic        we;
    logic [2:0]  idx;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int tper();
    return (per + 1) * (psc + 1);
  endfunction

  function automatic int cnt_after(input int m);
    return ((m - en_edge) / (psc + 1)) % (per + 1);
  endfunction

  function automatic int last_wrap(input int m);
    if (m - en_edge < tper()) return -1;
    return en_edge + ((m - en_edge) / tper()) * tper();
  endfunction

  function automatic int next_wrap(input int c);
    return en_edge + ((c - en_edge) / tper() + 1) * tper();
  endfunction

  function automatic logic [31:0] status_exp(input int m);
    logic f;
    f = last_wrap(m) >= clr_edge;
    return {15'd0, f, 16'(cnt_after(m))};
  endfunction

  function automatic logic [3:0] pwm_exp(input int m);
    logic [3:0] r;
    logic p;
    int d;
    p = (m >= pol_edge);
    if (m >= off_edge) return {4{p}};
    for (int n = 0; n < 4; n++) begin
      d = (m >= dsw[n]) ? dnew[n] : dold[n];
      r[n] = p ^ (cnt_after(m) < d);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    if (mon && cyc_n - 1 >= en_edge)
      chk("pwm_wave", 32'(pwm_q), 32'(pwm_exp(cyc_n - 1)));
  end

  // mode 0: no data check, 1: compare to exp, 2: STATUS from model
  task automatic xfer(input logic we, input logic [2:0] idx,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input int mode, input logic [31:0] exp);
    int lat;
    logic [31:0] e;
    @(negedge clk);
    bus.wb_cyc = 1'b1;
    bus.wb_stb = 1'b1;
    bus.wb_we  = we;
    bus.wb_adr = {3'b000, idx, 2'b00};
    bus.wb_dat = dat;
    bus.wb_sel = sel;
    if (mode == 1) sbq.push_back(exp);
    if (mode == 2) sbq.push_back(status_exp(cyc_n));
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.wb_ack && lat < 8);
    chk("ack_latency", 32'(lat), 32'd1);
    if (mode != 0) begin
      e = (sbq.size() > 0) ? sbq.pop_front() : 32'hdead_beef;
      chk($sformatf("rdata[%0d]", idx), bus.wb_rdt, e);
    end
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
    bus.wb_we  = 1'b0;
    @(posedge clk); #1;
    chk("ack_pulse", 32'(bus.wb_ack), 32'd0);
  endtask

  task automatic wait_phase(input int md, input int ph, input int after);
    int g;
    g = 0;
    while ((cyc_n <= after || ((cyc_n - en_edge) % md) != ph) && g < 500) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 500) begin
      errors++;
      $display("FAIL wait_phase: no phase %0d after 500 cycles", ph);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int c;
    bus.wb_cyc = 0; bus.wb_stb = 0; bus.wb_we = 0;
    bus.wb_sel = 0; bus.wb_adr = 0; bus.wb_dat = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwm", 32'(pwm_q), 32'd0);
    chk("rst_ack", 32'(bus.wb_ack), 32'd0);
    chk("rst_rdt", bus.wb_rdt, 32'd0);
`ifdef WB_PWM_IRQ_EN
    chk("rst_irq", 32'(irq), 32'd0);
`endif
    @(negedge clk) wb_rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      vt.push_back('{1'b0, 3'(i), 32'd0, 4'hf, 32'd0});
    vt.push_back('{1'b1, 3'd1, 32'hffff_ffff, 4'hf, 32'd0});
    vt.push_back('{1'b0, 3'd1, 32'd0, 4'hf, 32'h0000_ffff});
    vt.push_back('{1'b1, 3'd5, 32'h1234_5678, 4'h1, 32'd0});
    vt.push_back('{1'b0, 3'd5, 32'd0, 4'hf, 32'h0000_0078});
    vt.push_back('{1'b1, 3'd3, 32'hffff_abcd, 4'hf, 32'd0});
    vt.push_back('{1'b0, 3'd3, 32'd0, 4'hf, 32'h0000_abcd});
    vt.push_back('{1'b1, 3'd0, 32'hffff_ff06, 4'hf, 32'd0});
`ifdef WB_PWM_IRQ_EN
    vt.push_back('{1'b0, 3'd0, 32'd0, 4'hf, 32'h0000_ff06});
`else
    vt.push_back('{1'b0, 3'd0, 32'd0, 4'hf, 32'h0000_ff02});
`endif
    vt.push_back('{1'b1, 3'd0, 32'd0, 4'h1, 32'd0});
    vt.push_back('{1'b0, 3'd0, 32'd0, 4'hf, 32'h0000_ff00});
    vt.push_back('{1'b1, 3'd0, 32'd0, 4'hf, 32'd0});
    vt.push_back('{1'b0, 3'd0, 32'd0, 4'hf, 32'd0});
    vt.push_back('{1'b1, 3'd7, 32'hffff_ffff, 4'hf, 32'd0});
    vt.push_back('{1'b0, 3'd7, 32'd0, 4'hf, 32'd0});
    vt.push_back('{1'b1, 3'd6, 32'hffff_ffff, 4'hf, 32'd0});
    vt.push_back('{1'b0, 3'd6, 32'd0, 4'hf, 32'd0});

    foreach (vt[i])
      xfer(vt[i].we, vt[i].idx, vt[i].dat, vt[i].sel,
           vt[i].we ? 0 : 1, vt[i].exp);

    // held strobe: ack every second cycle
    @(negedge clk);
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1;
    bus.wb_we = 1'b0; bus.wb_adr = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("ack_b2b", 32'(bus.wb_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
    run(1);

    // PERIOD=9, PRESCALE=0, duties 3/0/15/5
    xfer(1, 3'd1, 32'd9,  4'hf, 0, 0);
    xfer(1, 3'd2, 32'd3,  4'hf, 0, 0);
    xfer(1, 3'd3, 32'd0,  4'hf, 0, 0);
    xfer(1, 3'd4, 32'd15, 4'hf, 0, 0);
    xfer(1, 3'd5, 32'd5,  4'hf, 0, 0);
    psc = 0; per = 9; clr_edge = 0;
    dold = '{3, 0, 15, 5}; dnew = dold; dsw = '{BIG, BIG, BIG, BIG};
    en_edge = cyc_n + 1;
    mon = 1;
    xfer(1, 3'd0, 32'h1, 4'hf, 0, 0);
    xfer(0, 3'd6, 0, 4'hf, 2, 0);
    run(25);
    xfer(0, 3'd6, 0, 4'hf, 2, 0);

    // mid-period DUTY0=7 waits for the wrap
    wait_phase(10, 3, 0);
    c = cyc_n + 1;
    dnew[0] = 7; dsw[0] = next_wrap(c);
    xfer(1, 3'd2, 32'd7, 4'hf, 0, 0);
    run(20);

    // DUTY0=2 landing on the wrap edge applies one period later
    wait_phase(10, 9, dsw[0] + 1);
    dold[0] = 7;
    c = cyc_n + 1;
    dnew[0] = 2; dsw[0] = next_wrap(c);
    xfer(1, 3'd2, 32'd2, 4'hf, 0, 0);
    run(25);

    // POL=1 inverts, then EN=0 parks all outputs at 1
    pol_edge = cyc_n + 1;
    xfer(1, 3'd0, 32'h3, 4'hf, 0, 0);
    run(12);
    off_edge = cyc_n + 1;
    xfer(1, 3'd0, 32'h2, 4'hf, 0, 0);
    run(5);
    chk("en0_pol", 32'(pwm_q), 32'hf);
    mon = 0;

    // PRESCALE=3, PERIOD=4
    xfer(1, 3'd0, 32'h0, 4'hf, 0, 0);
    xfer(1, 3'd1, 32'd4, 4'hf, 0, 0);
    psc = 3; per = 4;
    dold = '{2, 0, 15, 5}; dnew = dold; dsw = '{BIG, BIG, BIG, BIG};
    pol_edge = BIG; off_edge = BIG;
    en_edge = cyc_n + 1;
    mon = 1;
    xfer(1, 3'd0, 32'h0301, 4'hf, 0, 0);
    clr_edge = cyc_n + 1;
    xfer(1, 3'd6, 32'h0001_0000, 4'h4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      xfer(0, 3'd6, 0, 4'hf, 2, 0);
      run(i + 1);
    end
    run(20);
    wait_phase(20, 19, 0);
    clr_edge = cyc_n + 1;
    xfer(1, 3'd6, 32'h0001_0000, 4'h4, 0, 0);
    xfer(0, 3'd6, 0, 4'hf, 2, 0);
    chk("w1c_vs_wrap", 32'(status_exp(cyc_n)) >> 16, 32'd1);

`ifdef WB_PWM_IRQ_EN
    xfer(1, 3'd0, 32'h0305, 4'hf, 0, 0);
    chk("irq_set", 32'(irq), 32'd1);
    wait_phase(20, 5, 0);
    clr_edge = cyc_n + 1;
    xfer(1, 3'd6, 32'h0001_0000, 4'h4, 0, 0);
    chk("irq_clr", 32'(irq), 32'd0);
    wait_phase(20, 1, 0);
    chk("irq_rewrap", 32'(irq), 32'd1);
`endif

    // reset during a pending access drops the ack
    mon = 0;
    @(negedge clk);
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1;
    bus.wb_we = 1'b0; bus.wb_adr = 8'h18;
    wb_rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ack", 32'(bus.wb_ack), 32'd0);
    chk("rst_mid_pwm", 32'(pwm_q), 32'd0);
    chk("rst_mid_rdt", bus.wb_rdt, 32'd0);
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
    @(negedge clk) wb_rst = 1'b0;
    xfer(0, 3'd0, 0, 4'hf, 1, 32'd0);
    xfer(0, 3'd1, 0, 4'hf, 1, 32'd0);
    xfer(0, 3'd6, 0, 4'hf, 1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
